// File: rtl/accelerator_pkg.sv
// Shared types and constants for the vector-register write-back arbiter.
package accelerator_pkg;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_LOCK_ARITH,
        WB_LOCK_LSU
    } wb_arb_state_t;

    typedef enum logic {
        WB_SRC_ARITH,
        WB_SRC_LSU
    } wb_src_t;

    localparam int unsigned WB_MAX_BEATS = 4;

    // Round-robin successor of a source.
    function automatic wb_src_t wb_other_src(input wb_src_t src);
        return (src == WB_SRC_ARITH) ? WB_SRC_LSU : WB_SRC_ARITH;
    endfunction

endpackage

// File: rtl/vreg_wb_arbiter_if.sv
// Write-beat sources (arith, VLSU) and the vector register-file write port.
interface vreg_wb_arbiter_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 5
);
    logic              arith_valid_i;
    logic              arith_last_i;
    logic [ADDR_W-1:0] arith_addr_i;
    logic [DATA_W-1:0] arith_data_i;
    logic [1:0]        arith_etw_i;
    logic              arith_ready_o;

    logic              lsu_valid_i;
    logic              lsu_last_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_data_i;
    logic [1:0]        lsu_etw_i;
    logic              lsu_ready_o;

    logic              vreg_write_o;
    logic [ADDR_W-1:0] vreg_addr_o;
    logic [DATA_W-1:0] vreg_data_o;
    logic [1:0]        vreg_etw_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output arith_valid_i, arith_last_i, arith_addr_i, arith_data_i, arith_etw_i,
        output lsu_valid_i, lsu_last_i, lsu_addr_i, lsu_data_i, lsu_etw_i,
        input  arith_ready_o, lsu_ready_o,
        input  vreg_write_o, vreg_addr_o, vreg_data_o, vreg_etw_o, busy_o, err_o
    );

    modport slave (
        input  arith_valid_i, arith_last_i, arith_addr_i, arith_data_i, arith_etw_i,
        input  lsu_valid_i, lsu_last_i, lsu_addr_i, lsu_data_i, lsu_etw_i,
        output arith_ready_o, lsu_ready_o,
        output vreg_write_o, vreg_addr_o, vreg_data_o, vreg_etw_o, busy_o, err_o
    );
endinterface

// File: rtl/vreg_wb_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: bit 0 = arith, bit 1 = lsu.
module wb_rr_arb2
    import accelerator_pkg::*;
(
    input  logic [1:0] req,
    input  wb_src_t    ptr,
    output logic [1:0] gnt
);

    // On contention the pointer picks the winner; otherwise the lone requester wins.
    always_comb begin
        gnt = req;
        if (req[0] && req[1]) begin
            gnt = (ptr == WB_SRC_ARITH) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Arbitrates the single vector register-file write port between the arithmetic
// stage and the VLSU, locking the grant across multi-beat groups.
module vreg_wb_arbiter
    import accelerator_pkg::*;
#(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned MAX_BEATS = WB_MAX_BEATS
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             flush_i,
    vreg_wb_arbiter_if.slave wb
);

    localparam int unsigned     CNT_W    = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    wb_arb_state_t     state_q, state_d;
    wb_src_t           ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        etw_q;

    logic [1:0]        rr_gnt;
    logic              gnt_arith, gnt_lsu, accept, sel_last;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_etw;

    wb_rr_arb2 u_rr (
        .req ({wb.lsu_valid_i, wb.arith_valid_i}),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    // Grant, payload select and next arbitration state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        gnt_arith = 1'b0;
        gnt_lsu   = 1'b0;

        case (state_q)
            WB_IDLE: begin
                gnt_arith = rr_gnt[0];
                gnt_lsu   = rr_gnt[1];
            end
            WB_LOCK_ARITH: gnt_arith = wb.arith_valid_i;
            WB_LOCK_LSU:   gnt_lsu   = wb.lsu_valid_i;
            default: ;
        endcase

        // Readies must read 0 while flushing or held in reset.
        if (flush_i || !n_reset) begin
            gnt_arith = 1'b0;
            gnt_lsu   = 1'b0;
        end

        accept   = gnt_arith | gnt_lsu;
        sel_last = gnt_lsu ? wb.lsu_last_i : wb.arith_last_i;
        sel_addr = gnt_lsu ? wb.lsu_addr_i : wb.arith_addr_i;
        sel_data = gnt_lsu ? wb.lsu_data_i : wb.arith_data_i;
        sel_etw  = gnt_lsu ? wb.lsu_etw_i  : wb.arith_etw_i;

        if (flush_i) begin
            state_d = WB_IDLE;
            cnt_d   = '0;
            ptr_d   = WB_SRC_ARITH;
        end else if (accept) begin
            // A beat at the counter ceiling closes the group even without last.
            if (sel_last || cnt_q == CNT_LAST) begin
                state_d = WB_IDLE;
                cnt_d   = '0;
                ptr_d   = wb_other_src(gnt_lsu ? WB_SRC_LSU : WB_SRC_ARITH);
                if (!sel_last) begin
                    err_d = 1'b1;
                end
            end else begin
                state_d = gnt_lsu ? WB_LOCK_LSU : WB_LOCK_ARITH;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // Arbitration state: FSM, round-robin pointer, beat counter, sticky error.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= WB_IDLE;
            ptr_q   <= WB_SRC_ARITH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Registered write port; payload holds when no beat is accepted.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            etw_q   <= '0;
        end else begin
            write_q <= accept;
            if (accept) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
                etw_q  <= sel_etw;
            end
        end
    end

    assign wb.arith_ready_o = gnt_arith;
    assign wb.lsu_ready_o   = gnt_lsu;
    assign wb.vreg_write_o  = write_q;
    assign wb.vreg_addr_o   = addr_q;
    assign wb.vreg_data_o   = data_q;
    assign wb.vreg_etw_o    = etw_q;
    assign wb.busy_o        = (state_q != WB_IDLE) | write_q;
    assign wb.err_o         = err_q;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Directed scoreboard bench for vreg_wb_arbiter.
module tb_vreg_wb_arbiter;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        etw;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic flush_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    vreg_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    vreg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .flush_i (flush_i),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic l, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [1:0] e);
        wb.arith_valid_i = v;
        wb.arith_last_i  = l;
        wb.arith_addr_i  = a;
        wb.arith_data_i  = d;
        wb.arith_etw_i   = e;
    endtask

    task automatic drive_l(input logic v, input logic l, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [1:0] e);
        wb.lsu_valid_i = v;
        wb.lsu_last_i  = l;
        wb.lsu_addr_i  = a;
        wb.lsu_data_i  = d;
        wb.lsu_etw_i   = e;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, '0, '0, '0);
        drive_l(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Called at posedge+1 after inputs are driven: check readies, queue the
    // expected write for the beat the bench expects accepted, advance a cycle.
    task automatic cyc(input string nm, input logic ea, input logic el);
        exp_t e;
        #1;
        chk({nm, " arith_ready"}, wb.arith_ready_o, ea);
        chk({nm, " lsu_ready"}, wb.lsu_ready_o, el);
        if (ea) begin
            e.addr = wb.arith_addr_i; e.data = wb.arith_data_i; e.etw = wb.arith_etw_i;
            sb.push_back(e);
        end
        if (el) begin
            e.addr = wb.lsu_addr_i; e.data = wb.lsu_data_i; e.etw = wb.lsu_etw_i;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        flush_i = 1'b0;
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    // Monitor: every presented write must match the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (wb.vreg_write_o) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra_write: got write addr %0d, expected no write", wb.vreg_addr_o);
            end else begin
                e = sb.pop_front();
                chk("sb_addr", wb.vreg_addr_o, e.addr);
                chk("sb_data", wb.vreg_data_o, e.data);
                chk("sb_etw", wb.vreg_etw_o, e.etw);
            end
        end
    end

    initial begin
        idle();
        // Reset state, with arith valid to show ready is held low in reset.
        drive_a(1'b1, 1'b1, 5'd1, {4{32'h1111_2222}}, 2'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst vreg_write", wb.vreg_write_o, 1'b0);
        chk("rst vreg_addr", wb.vreg_addr_o, '0);
        chk("rst vreg_data", wb.vreg_data_o, '0);
        chk("rst vreg_etw", wb.vreg_etw_o, '0);
        chk("rst arith_ready", wb.arith_ready_o, 1'b0);
        chk("rst lsu_ready", wb.lsu_ready_o, 1'b0);
        chk("rst busy", wb.busy_o, 1'b0);
        chk("rst err", wb.err_o, 1'b0);
        idle();
        n_reset = 1'b1;

        // Single arith beat.
        drive_a(1'b1, 1'b1, 5'd3, {16{8'hA5}}, 2'd2);
        cyc("t1_c0", 1'b1, 1'b0);
        idle();
        chk("t1 write_pulse", wb.vreg_write_o, 1'b1);
        chk("t1 busy_pending", wb.busy_o, 1'b1);
        cyc("t1_c1", 1'b0, 1'b0);
        chk("t1 write_off", wb.vreg_write_o, 1'b0);
        chk("t1 addr_hold", wb.vreg_addr_o, 5'd3);
        chk("t1 busy_clear", wb.busy_o, 1'b0);

        // Both valid from reset: arith first, then lsu.
        do_reset();
        drive_a(1'b1, 1'b1, 5'd4, {4{32'hDEAD_BEEF}}, 2'd1);
        drive_l(1'b1, 1'b1, 5'd5, {4{32'hCAFE_F00D}}, 2'd3);
        cyc("t2_c0", 1'b1, 1'b0);
        drive_a(1'b0, 1'b0, '0, '0, '0);
        cyc("t2_c1", 1'b0, 1'b1);
        idle();
        cyc("t2_c2", 1'b0, 1'b0);

        // LSU 4-beat locked group with a bubble, arith waiting throughout.
        do_reset();
        drive_a(1'b1, 1'b1, 5'd7, {8{16'h0707}}, 2'd0);
        cyc("t3_pre", 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 5'd8, {8{16'h0808}}, 2'd1);
        drive_l(1'b1, 1'b0, 5'd9, {4{32'h9000_0000}}, 2'd0);
        cyc("t3_b1", 1'b0, 1'b1);
        drive_l(1'b1, 1'b0, 5'd9, {4{32'h9000_0001}}, 2'd1);
        cyc("t3_b2", 1'b0, 1'b1);
        drive_l(1'b0, 1'b0, '0, '0, '0);
        chk("t3 busy_lock", wb.busy_o, 1'b1);
        cyc("t3_bubble", 1'b0, 1'b0);
        chk("t3 bubble_no_write", wb.vreg_write_o, 1'b0);
        drive_l(1'b1, 1'b0, 5'd9, {4{32'h9000_0002}}, 2'd2);
        cyc("t3_b3", 1'b0, 1'b1);
        drive_l(1'b1, 1'b1, 5'd9, {4{32'h9000_0003}}, 2'd3);
        cyc("t3_b4", 1'b0, 1'b1);
        drive_l(1'b0, 1'b0, '0, '0, '0);
        cyc("t3_after", 1'b1, 1'b0);
        idle();
        cyc("t3_idle", 1'b0, 1'b0);
        chk("t3 err", wb.err_o, 1'b0);

        // LSU overrun: four beats, none marked last.
        do_reset();
        drive_l(1'b1, 1'b0, 5'd12, {4{32'h4000_0000}}, 2'd1);
        cyc("t4_b1", 1'b0, 1'b1);
        drive_a(1'b1, 1'b1, 5'd2, {4{32'h4A4A_4A4A}}, 2'd3);
        drive_l(1'b1, 1'b0, 5'd12, {4{32'h4000_0001}}, 2'd1);
        cyc("t4_b2", 1'b0, 1'b1);
        drive_l(1'b1, 1'b0, 5'd12, {4{32'h4000_0002}}, 2'd1);
        cyc("t4_b3", 1'b0, 1'b1);
        chk("t4 err_before", wb.err_o, 1'b0);
        drive_l(1'b1, 1'b0, 5'd12, {4{32'h4000_0003}}, 2'd1);
        cyc("t4_b4", 1'b0, 1'b1);
        chk("t4 err_set", wb.err_o, 1'b1);
        drive_l(1'b0, 1'b0, '0, '0, '0);
        cyc("t4_after", 1'b1, 1'b0);
        idle();
        cyc("t4_idle0", 1'b0, 1'b0);
        cyc("t4_idle1", 1'b0, 1'b0);
        chk("t4 err_sticky", wb.err_o, 1'b1);

        // Flush while LOCK_LSU with both sources valid.
        do_reset();
        chk("t5 err_cleared", wb.err_o, 1'b0);
        drive_l(1'b1, 1'b0, 5'd20, {4{32'h5150_0000}}, 2'd0);
        cyc("t5_b1", 1'b0, 1'b1);
        flush_i = 1'b1;
        drive_a(1'b1, 1'b1, 5'd21, {4{32'h5A5A_0021}}, 2'd2);
        drive_l(1'b1, 1'b0, 5'd20, {4{32'h5150_0001}}, 2'd1);
        chk("t5 prior_write", wb.vreg_write_o, 1'b1);
        cyc("t5_flush", 1'b0, 1'b0);
        flush_i = 1'b0;
        cyc("t5_post", 1'b1, 1'b0);
        idle();
        cyc("t5_idle", 1'b0, 1'b0);

        // Asynchronous reset in the middle of an arith group.
        do_reset();
        drive_a(1'b1, 1'b0, 5'd25, {4{32'h6600_0000}}, 2'd1);
        cyc("t6_b1", 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 5'd25, {4{32'h6600_0001}}, 2'd2);
        #1;
        chk("t6 lock_ready", wb.arith_ready_o, 1'b1);
        @(negedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        chk("t6 rst_write", wb.vreg_write_o, 1'b0);
        chk("t6 rst_addr", wb.vreg_addr_o, '0);
        chk("t6 rst_data", wb.vreg_data_o, '0);
        chk("t6 rst_etw", wb.vreg_etw_o, '0);
        chk("t6 rst_arith_ready", wb.arith_ready_o, 1'b0);
        chk("t6 rst_lsu_ready", wb.lsu_ready_o, 1'b0);
        chk("t6 rst_busy", wb.busy_o, 1'b0);
        idle();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        drive_l(1'b1, 1'b1, 5'd30, {4{32'h6C6C_0030}}, 2'd3);
        cyc("t6_new", 1'b0, 1'b1);
        idle();
        cyc("t6_idle0", 1'b0, 1'b0);
        cyc("t6_idle1", 1'b0, 1'b0);

        chk("sb_drained", DATA_W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vreg_wb_arbiter.md
Name: vreg_wb_arbiter

Overview:
Shares the single vector-register-file write port between the arithmetic stage and the VLSU. Each source presents write beats over valid/ready. The block arbitrates round-robin and locks the grant across a multi-beat group until its last beat. It drives a registered write port (write, vd address, 128b data, elements_to_write) into the vector registers, replacing the current OR-ed write enable and source mux.

Parameters:
DATA_W, 128, vector register data width (bits)
ADDR_W, 5, vector register address width
MAX_BEATS, 4, max beats per locked group; matches the 2-bit cycle_count

Ports:
clk  input  1  clock
n_reset  input  1  asynchronous active-low reset
flush_i  input  1  synchronous abort of arbitration state
arith_valid_i  input  1  arith beat valid
arith_last_i  input  1  final beat of arith group
arith_addr_i  input  ADDR_W  destination vd
arith_data_i  input  DATA_W  write data
arith_etw_i  input  2  elements_to_write for beat
arith_ready_o  output  1  arith beat accepted this cycle
lsu_valid_i, lsu_last_i, lsu_addr_i, lsu_data_i, lsu_etw_i  input  1/1/ADDR_W/DATA_W/2  same meaning, VLSU source
lsu_ready_o  output  1  lsu beat accepted this cycle
vreg_write_o  output  1  register-file write enable
vreg_addr_o  output  ADDR_W  write address
vreg_data_o  output  DATA_W  write data
vreg_etw_o  output  2  elements_to_write
busy_o  output  1  group locked or write pending
err_o  output  1  sticky: group exceeded MAX_BEATS without last

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, n_reset.
- Reset state: state IDLE; rr pointer prefers ARITH; beat counter 0. All outputs 0: vreg_*, readies, busy_o, err_o.
- Transfer: occurs when valid & ready. A source holds valid and payload stable until accepted. ready_o is combinational from state, pointer, and valids; it never depends on the source's own ready.
- Latency: an accepted beat appears on vreg_* exactly 1 cycle later, with vreg_write_o=1 for one cycle. No beat is accepted → vreg_write_o=0 next cycle, and addr/data/etw hold their previous values.
- States:
  - IDLE, one valid: grant that source.
  - IDLE, both valid: grant the source the pointer prefers.
  - Granted beat has last=1: stay IDLE, pointer moves to the other source.
  - Granted beat has last=0: go to LOCK_ARITH or LOCK_LSU, beat counter=1.
  - LOCK_x: only x may get ready; the other source's ready=0.
  - LOCK_x, x not valid: bubble cycle, no write, counter unchanged.
  - LOCK_x, x beat accepted: counter+1.
  - LOCK_x, accepted beat has last=1: go to IDLE, pointer moves to the other source, counter=0.
- Overrun: the beat with counter==MAX_BEATS-1 and last=0 is treated as last. Return to IDLE, pointer flips, err_o set until reset.
- flush_i=1:
  - Both readies are 0 that cycle.
  - state→IDLE, counter→0, pointer→ARITH.
  - A write already registered still appears on vreg_* (it was accepted the previous cycle).
  - flush_i overrides simultaneous valids.
- busy_o = (state!=IDLE) | vreg_write_o.
- Reset asserted mid-group: immediate return to reset state; the partial group is dropped. The sources restart the group after reset.
- No data transformation: addr, data and etw pass through the output register unchanged.

Decomposition:
- Shared package (accelerator_pkg):
  - typedef enum wb_arb_state_t {WB_IDLE, WB_LOCK_ARITH, WB_LOCK_LSU}.
  - typedef enum wb_src_t {WB_SRC_ARITH, WB_SRC_LSU}.
  - Constant WB_MAX_BEATS=4.
- One natural sub-module: wb_rr_arb2, a combinational 2-way round-robin grant from valids plus pointer, reused by future requesters. State, counter and output register stay in vreg_wb_arbiter.

Test Plan:
- Reset, then only arith_valid with last=1, addr=3, data=0xA5.., etw=2 → arith_ready=1 same cycle; next cycle vreg_write=1, addr=3, data/etw match; lsu_ready=0 throughout.
- Both valid from reset, each last=1, held 2 cycles → cycle0 ARITH granted, cycle1 LSU granted; vreg_write sequence ARITH then LSU.
- LSU 4-beat group (last on beat 4) with arith valid throughout and one LSU bubble after beat 2 → arith_ready stays 0 for 5 cycles; 4 LSU writes, with one write-free cycle at the bubble; arith granted the cycle after the LSU last beat.
- LSU group of 4 beats, all last=0 → after beat 4 state IDLE, err_o=1 and stays 1; arith granted next cycle.
- flush_i pulsed while LOCK_LSU with both valid → both readies 0 that cycle; the prior beat's write still appears; next cycle ARITH granted (pointer reset).
- n_reset asserted asynchronously mid-group → all outputs 0 immediately; after release, a new single-beat group is accepted normally.
